// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   ARB_N_MAX   : largest supported requester count
//   ARB_CNT_W   : width of the holder idle-timeout counter
//   arb_state_e : arbiter FSM state
//   idx_w()     : index width for an N-entry requester vector (at least 1 bit)
package uart_arb_pkg;

   localparam int unsigned ARB_N_MAX = 8;
   localparam int unsigned ARB_CNT_W = 16;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_tx-side signals around the arbiter.
//   req_e/req_r/req_d/req_last : per-requester byte stream (valid, ready, data, end of packet)
//   tx_e/tx_r/tx_d             : single byte stream to uart_tx (i_e, i_r, i_d)
//   gnt                        : one-hot current holder, zero when idle
//   drop                       : one-cycle pulse when a grant is revoked by timeout
// Modports: slave = arbiter side, master = requesters plus uart_tx side.
interface uart_tx_arbiter_if #(
   parameter int unsigned N = 4
) ();

   logic [N-1:0]      req_e;
   logic [N-1:0]      req_r;
   logic [N-1:0][7:0] req_d;
   logic [N-1:0]      req_last;
   logic              tx_e;
   logic              tx_r;
   logic [7:0]        tx_d;
   logic [N-1:0]      gnt;
   logic              drop;

   modport slave (
      input  req_e, req_d, req_last, tx_r,
      output req_r, tx_e, tx_d, gnt, drop
   );

   modport master (
      output req_e, req_d, req_last, tx_r,
      input  req_r, tx_e, tx_d, gnt, drop
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   req_i : request vector
//   ptr_i : index of the previous winner; the search starts at ptr_i+1, wrapping modulo N
//   gnt_o : one-hot winner
//   idx_o : index of the winner
//   any_o : at least one request is set
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      // Visit ptr+1, ptr+2, ..., ptr+N (mod N); the last visit is ptr itself.
      for (int unsigned i = 1; i <= N; i++) begin
         cand = IW'((32'(ptr_i) + i) % N);
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_tx serializer between N requesters.
// A granted requester keeps the serializer until its last byte is accepted, so packets
// from different sources never interleave. The byte path is a combinational grant mux.
//   clk  : system clock
//   rstn : synchronous active-low reset
//   bus  : uart_tx_arbiter_if.slave (requester streams, uart_tx stream, gnt, drop)
// Parameters: N requesters (2..8); TIMEOUT idle-cycle limit for the holder.
// Build option: define UART_ARB_TIMEOUT_EN to revoke a holder that leaves req_e low for
// TIMEOUT consecutive cycles (drop pulses); otherwise drop is tied 0 and a stalled holder
// keeps the grant.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned          N       = 4,
   parameter logic [ARB_CNT_W-1:0] TIMEOUT = 16'd50000
) (
   input logic              clk,
   input logic              rstn,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned IW = idx_w(N);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   // Index of the current holder while busy, of the last holder while idle.
   logic [IW-1:0] ptr_q, ptr_d;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          pick_any;

   logic busy;
   logic hold_e;
   logic xfer;
   logic xfer_last;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_rr_pick (
      .req_i (bus.req_e),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Outputs are gated by rstn so a reset cycle never completes a handshake.
   assign busy      = (state_q == ARB_BUSY) && rstn;
   assign hold_e    = bus.req_e[ptr_q];
   assign xfer      = busy && hold_e && bus.tx_r;
   assign xfer_last = xfer && bus.req_last[ptr_q];

   assign bus.tx_e  = busy && hold_e;
   assign bus.tx_d  = busy ? bus.req_d[ptr_q] : 8'h00;
   assign bus.req_r = (busy && bus.tx_r) ? gnt_q : '0;
   assign bus.gnt   = gnt_q;

`ifdef UART_ARB_TIMEOUT_EN
   logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
   logic                 drop_q, drop_d;

   assign bus.drop = drop_q;
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT;
   assign bus.drop       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      drop_d  = 1'b0;
`endif
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BUSY;
               gnt_d   = pick_gnt;
               ptr_d   = pick_idx;
            end
         end
         ARB_BUSY: begin
            if (xfer_last) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
`ifdef UART_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (hold_e) begin
               cnt_d = '0;
            end else if (cnt_q == TIMEOUT - 16'd1) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
               drop_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         // Start the search at requester 0.
         ptr_q   <= IW'(N - 1);
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         drop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
`endif
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares one `uart_tx` byte serializer between N requesters (debug monitors, parameter dumpers, status printers). Each requester streams bytes with a `last` marker. Once granted, a requester owns the serializer until its last byte is accepted, so text lines from different sources never interleave. Sits directly in front of `uart_tx`: its `tx_*` ports connect to `uart_tx` `i_e`/`i_r`/`i_d`.

## Interface
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16'd50000: idle-cycle limit for the grant holder. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset, synchronous, active-low. One clock; all state updates on posedge `clk`.
- `req_e`  in  N  per-requester byte valid.
- `req_r`  out  N  per-requester byte ready.
- `req_d`  in  N×8  per-requester byte, packed `[N-1:0][7:0]`.
- `req_last`  in  N  marks the final byte of a packet; qualified by `req_e`.
- `tx_e`  out  1  byte valid to `uart_tx` `i_e`.
- `tx_r`  in  1  `uart_tx` `i_r`.
- `tx_d`  out  8  byte to `uart_tx` `i_d`.
- `gnt`  out  N  one-hot registered grant; all-zero when idle.
- `drop`  out  1  one-cycle pulse when a grant is revoked by timeout. Tied 0 without the macro.

## Operation
- States: IDLE, BUSY.
- IDLE:
  - `tx_e`=0 and `req_r`=0.
  - If any `req_e` is set, select the first set bit searching from `ptr+1` upward, modulo N.
  - Register `gnt` to that one-hot value and `ptr` to its index, then go to BUSY.
- BUSY, holder g:
  - `tx_e` = `req_e[g]`, `tx_d` = `req_d[g]`, `req_r[g]` = `tx_r`. All other `req_r` bits are 0.
  - A transfer occurs when `req_e[g] && tx_r`.
  - A transfer with `req_last[g]`=1 returns the block to IDLE and clears `gnt`.
- Fairness: `ptr` holds the last holder. The next search starts after it, giving strict round-robin.
- Reset: state IDLE, `gnt`=0, `ptr`=N-1 (requester 0 has first priority), `drop`=0, timeout counter 0.
- Reset mid-packet:
  - The arbiter drops the grant immediately.
  - A byte already accepted by `uart_tx` completes there; that is not this block's concern.
  - Requesters must restart their packet.
- Dropping `req_e` mid-packet is legal. The grant is held until the last byte (or timeout).
- `req_d`/`req_last` of non-granted requesters are ignored.

## Timing
- Arbitration latency: 1 cycle from `req_e` seen in IDLE to BUSY with `gnt` valid.
- First byte can be presented to `tx_e` in that BUSY cycle.
- Packet boundary cost: one IDLE bubble cycle between consecutive packets, including from the same requester.
- Data path `req_*`→`tx_*` is combinational through the grant mux; there is no byte buffering.
- Byte throughput is bounded by `uart_tx`: one byte per 12×CLK_DIV cycles.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - In BUSY, a 16-bit counter increments every cycle with `req_e[g]`=0 and clears on any cycle with `req_e[g]`=1.
  - When the counter reaches `TIMEOUT`-1 with `req_e[g]` still 0, go to IDLE, clear `gnt`, pulse `drop` for one cycle, and clear the counter.
  - If a last-byte transfer and timeout coincide, the transfer wins and `drop` stays 0.
- Not defined: no counter; a stalled holder keeps the grant indefinitely; `drop`=0.

## Structure
- Package `uart_arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY`), `ARB_N_MAX`=8, timeout counter width 16.
- Sub-module `rr_pick`: combinational round-robin priority encoder. Inputs: request vector and `ptr`. Outputs: one-hot grant, index, and any-valid flag.

## Test plan
- Reset, no requests: `gnt`=0, `tx_e`=0, `drop`=0 indefinitely.
- Requester 1 sends "OK\n" (0x4F, 0x4B, 0x0A with `last` on 0x0A), `tx_r` modeled as a `uart_tx` with CLK_DIV=4:
  - `gnt`=4'b0010 one cycle after `req_e`.
  - `tx_d` sequence is 0x4F, 0x4B, 0x0A.
  - IDLE one cycle after 0x0A is accepted.
- All four requesters hold continuous 2-byte packets:
  - Grant order is 0, 1, 2, 3, 0, …
  - No byte from another requester appears inside a packet.
- Requester 2 granted, then requester 0 asserts `req_e` mid-packet: requester 0 is not granted until requester 2's last byte transfers.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=8:
  - Holder sends one non-last byte, then drops `req_e`.
  - `drop` pulses exactly 8 idle cycles later, and the next requester is granted on the following cycle.
- `rstn` asserted for one cycle mid-packet: next cycle IDLE, `gnt`=0; after release, requester 0 is favoured.
